// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Package     : battleship_pkg
// Description : Shared types and helpers for the ship-placement cursor logic.
// Revision    : 1.0 - initial release
// ============================================================================
package battleship_pkg;

   localparam int BOARD_N = 5;

   typedef logic [2:0] coord_t;

   typedef enum logic [1:0] {
      PC_IDLE    = 2'd0,
      PC_PLACING = 2'd1,
      PC_DONE    = 2'd2
   } place_state_t;

   // Step one position towards zero, wrapping from 0 to the last legal coordinate.
   function automatic coord_t wrap_dec(input coord_t c, input coord_t last);
      return (c == '0) ? last : c - coord_t'(1);
   endfunction

   // Step one position away from zero, wrapping from the last legal coordinate to 0.
   function automatic coord_t wrap_inc(input coord_t c, input coord_t last);
      return (c == last) ? '0 : c + coord_t'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/placement_cursor_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Synchronizes a raw push button, filters contact bounce and
//               emits a single-cycle pulse on each accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             stable_q;
   logic             stable_d;
   logic             stable_prev_q;

   // Candidate level must disagree with the accepted level for a full
   // debounce window before it replaces it; any agreement restarts the window.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d    = '0;
         stable_d = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Two-flop synchronizer, debounce state and edge-detect history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         cnt_q         <= '0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
      end else begin
         sync1_q       <= btn_raw;
         sync2_q       <= sync1_q;
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
      end
   end

   assign btn_level = stable_q;
   assign btn_press = stable_q & ~stable_prev_q;

endmodule
`default_nettype wire

// File: rtl/placement_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : placement_cursor_ctrl
// Description : Board-button cursor with wrap-around, remaining-ship counter
//               and placement FSM feeding the ship-colocation stage.
// Revision    : 1.0 - initial release
// ============================================================================
module placement_cursor_ctrl
   import battleship_pkg::*;
#(
   parameter int BOARD_N         = battleship_pkg::BOARD_N,
   parameter int INITIAL_SHIPS   = 3,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       confirm_placement,
   input  logic       placement_error,
   output logic [2:0] i_actual,
   output logic [2:0] j_actual,
   output logic [2:0] ship_len,
   output logic [2:0] ships_remaining,
   output logic       all_placed,
   output logic       error_seen
);

   localparam coord_t     LAST_COORD = coord_t'(BOARD_N - 1);
   localparam logic [2:0] SHIPS_INIT = 3'(INITIAL_SHIPS);

   // Button index order doubles as move priority: lowest index wins.
   localparam int IDX_UP    = 0;
   localparam int IDX_DOWN  = 1;
   localparam int IDX_LEFT  = 2;
   localparam int IDX_RIGHT = 3;

   logic [3:0]   btn_raw;
   logic [3:0]   btn_press;

   place_state_t state_q;
   place_state_t state_d;
   coord_t       i_q;
   coord_t       i_d;
   coord_t       j_q;
   coord_t       j_d;
   logic [2:0]   ships_q;
   logic [2:0]   ships_d;
   logic         all_placed_q;
   logic         all_placed_d;
   logic         error_seen_q;
   logic         error_seen_d;
   logic         confirm_prev_q;
   logic         error_prev_q;
   logic         confirm_rise;
   logic         error_rise;

   assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

   genvar b;
   generate
      for (b = 0; b < 4; b++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (btn_raw[b]),
            .btn_level (),
            .btn_press (btn_press[b])
         );
      end
   endgenerate

   assign confirm_rise = confirm_placement & ~confirm_prev_q;
   assign error_rise   = placement_error & ~error_prev_q;

   // Next-state logic: FSM transitions plus cursor, ship-count and error updates.
   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      j_d          = j_q;
      ships_d      = ships_q;
      error_seen_d = error_seen_q;
      case (state_q)
         PC_IDLE: begin
            if (enable) state_d = PC_PLACING;
         end
         PC_PLACING: begin
            if (!enable) begin
               state_d = PC_IDLE;
            end else begin
               if (btn_press[IDX_UP])         i_d = wrap_dec(i_q, LAST_COORD);
               else if (btn_press[IDX_DOWN])  i_d = wrap_inc(i_q, LAST_COORD);
               else if (btn_press[IDX_LEFT])  j_d = wrap_dec(j_q, LAST_COORD);
               else if (btn_press[IDX_RIGHT]) j_d = wrap_inc(j_q, LAST_COORD);

               if (confirm_rise && (ships_q != 3'd0)) begin
                  ships_d = ships_q - 3'd1;
                  if (ships_q == 3'd1) state_d = PC_DONE;
               end

               if (error_rise) error_seen_d = 1'b1;
            end
         end
         PC_DONE: begin
            state_d = PC_DONE;
         end
         default: begin
            state_d = PC_IDLE;
         end
      endcase
      all_placed_d = (state_d == PC_DONE);
   end

   // State, cursor, counters and input edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= PC_IDLE;
         i_q            <= '0;
         j_q            <= '0;
         ships_q        <= SHIPS_INIT;
         all_placed_q   <= 1'b0;
         error_seen_q   <= 1'b0;
         confirm_prev_q <= 1'b0;
         error_prev_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         i_q            <= i_d;
         j_q            <= j_d;
         ships_q        <= ships_d;
         all_placed_q   <= all_placed_d;
         error_seen_q   <= error_seen_d;
         confirm_prev_q <= confirm_placement;
         error_prev_q   <= placement_error;
      end
   end

   assign i_actual        = i_q;
   assign j_actual        = j_q;
   assign ships_remaining = ships_q;
   assign ship_len        = ships_q;
   assign all_placed      = all_placed_q;
   assign error_seen      = error_seen_q;

endmodule
`default_nettype wire
